// File: rtl/fft_twiddle_feed.sv
// Twiddle feeder for the DIF butterfly multiplier: pairs each stage sample with W_N^e
// from a quarter-wave cosine ROM, both delayed by the same two-stage pipeline.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

module fft_twiddle_feed #(
  parameter int LOG_N_MAX = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_load,
  input  logic [$clog2(LOG_N_MAX+1)-1:0]       cfg_log_n,
  input  logic [$clog2(LOG_N_MAX)-1:0]         cfg_stage,
  output logic                                 cfg_err,
  input  logic                                 in_valid,
  input  logic [2*`FFT_DATA_WIDTH-1:0]         in_data,
  output logic                                 out_valid,
  output logic [2*`FFT_DATA_WIDTH-1:0]         out_opa,
  output logic [2*`FFT_DATA_WIDTH-1:0]         out_opb,
  output logic                                 out_last
);

  localparam int W         = `FFT_DATA_WIDTH;
  localparam int N_MAX     = 1 << LOG_N_MAX;
  localparam int Q         = N_MAX / 4;
  localparam int ROM_DEPTH = Q + 1;
  localparam int AW        = $clog2(ROM_DEPTH);
  localparam int LN_W      = $clog2(LOG_N_MAX + 1);
  localparam int S_W       = $clog2(LOG_N_MAX);
  localparam int PW        = LOG_N_MAX;
  localparam real PI       = 3.14159265358979323846;
  localparam logic [PW:0] QV = (PW+1)'(Q);

  typedef logic signed [W-1:0] rom_t [ROM_DEPTH];

  function automatic rom_t gen_rom();
    rom_t t;
    real  amp;
    real  a;
    amp = real'((1 << (W-1)) - 1);
    for (int unsigned k = 0; k < ROM_DEPTH; k++) begin
      a    = $cos(2.0 * PI * real'(k) / real'(N_MAX)) * amp;
      t[k] = W'(a >= 0.0 ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5));
    end
    return t;
  endfunction

  localparam rom_t C_ROM = gen_rom();

  logic [LN_W-1:0]  r_log_n;
  logic [S_W-1:0]   r_s;
  logic             r_err;
  logic [PW-1:0]    r_p;

  logic             r_vld1;
  logic             r_last1;
  logic             r_neg1;
  logic [AW-1:0]    r_addr_c;
  logic [AW-1:0]    r_addr_s;
  logic [2*W-1:0]   r_data1;

  logic [LN_W-1:0]  w_log_n;
  logic [S_W-1:0]   w_s;
  logic             w_err;
  logic             w_cfg_bad;
  logic [PW-1:0]    w_p;
  logic [LN_W-1:0]  w_lb;
  logic [PW:0]      w_len;
  logic [PW:0]      w_half;
  logic [PW:0]      w_pe;
  logic [PW:0]      w_e;
  logic [PW:0]      w_E;
  logic             w_last;
  logic             w_neg;
  logic [AW-1:0]    w_addr_c;
  logic [AW-1:0]    w_addr_s;
  logic signed [W-1:0] w_cos;
  logic signed [W-1:0] w_sin;

  assign w_cfg_bad = (cfg_log_n == '0) || (cfg_log_n > LN_W'(LOG_N_MAX)) ||
                     ((LN_W+1)'(cfg_stage) >= (LN_W+1)'(cfg_log_n));

  // A load takes effect for a sample arriving in the same cycle, so decode from the
  // incoming config and p=0 rather than the latched state.
  always_comb begin
    w_log_n  = cfg_load ? cfg_log_n : r_log_n;
    w_s      = cfg_load ? cfg_stage : r_s;
    w_err    = cfg_load ? w_cfg_bad : r_err;
    w_p      = cfg_load ? '0 : r_p;
    w_lb     = w_err ? '0 : (w_log_n - LN_W'(w_s));
    w_len    = (PW+1)'(1) << w_lb;
    w_half   = w_len >> 1;
    w_pe     = {1'b0, w_p};
    w_last   = (w_pe == (w_len - 1'b1));
    w_e      = (w_pe >= w_half) ? ((w_pe - w_half) << w_s) : '0;
    w_E      = w_err ? '0 : (w_e << (LN_W'(LOG_N_MAX) - w_log_n));
    w_neg    = 1'b0;
    w_addr_c = AW'(w_E);
    w_addr_s = AW'(QV - w_E);
    if (w_E > QV) begin
      w_neg    = 1'b1;
      w_addr_c = AW'((QV << 1) - w_E);
      w_addr_s = AW'(w_E - QV);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_log_n <= LN_W'(1);
      r_s     <= '0;
      r_err   <= 1'b0;
      r_p     <= '0;
    end else begin
      if (cfg_load) begin
        r_log_n <= cfg_log_n;
        r_s     <= cfg_stage;
        r_err   <= w_cfg_bad;
      end
      if (in_valid)
        r_p <= w_last ? '0 : (w_p + 1'b1);
      else if (cfg_load)
        r_p <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld1   <= 1'b0;
      r_last1  <= 1'b0;
      r_neg1   <= 1'b0;
      r_addr_c <= '0;
      r_addr_s <= '0;
      r_data1  <= '0;
    end else begin
      r_vld1 <= in_valid;
      if (in_valid) begin
        r_last1  <= w_last;
        r_neg1   <= w_neg;
        r_addr_c <= w_addr_c;
        r_addr_s <= w_addr_s;
        r_data1  <= in_data;
      end
    end
  end

  assign w_cos = C_ROM[r_addr_c];
  assign w_sin = C_ROM[r_addr_s];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_opa   <= '0;
      out_opb   <= '0;
    end else begin
      out_valid <= r_vld1;
      out_last  <= r_vld1 & r_last1;
      if (r_vld1) begin
        out_opa <= r_data1;
        out_opb <= {(r_neg1 ? -w_cos : w_cos), -w_sin};
      end
    end
  end

  assign cfg_err = r_err;

endmodule
